// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Definitions shared by the window generator and the downstream Sobel stage:
//   PIX_W      - grayscale pixel width
//   WIN_PIXELS - pixels in one 3x3 neighbourhood
//   state_t    - window generator control states
//   win_idx()  - maps window (row, col) to its byte offset in the packed window
// -----------------------------------------------------------------------------
package sobel_pkg;

    localparam int PIX_W      = 8;
    localparam int WIN_PIXELS = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Byte r*3+c of a packed window holds pixel (win_y+r, win_x+c).
    function automatic int win_idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// -----------------------------------------------------------------------------
// sobel_line_buffer
// One image row of storage. Read is combinational; a write lands at the clock
// edge, so a read of the address being written returns the previous contents.
// Ports:
//   clk   - clock
//   we    - write enable
//   addr  - shared read/write column address
//   wdata - pixel to store
//   rdata - pixel currently stored at addr
// -----------------------------------------------------------------------------
module sobel_line_buffer #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset: stale rows are never emitted.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// -----------------------------------------------------------------------------
// sobel_window_gen
// Turns a raster-order pixel stream into 3x3 neighbourhoods, one per interior
// output position, (W-2)x(H-2) windows per frame in raster order.
// Ports:
//   clk, rstn             - clock, asynchronous active-low reset
//   start, cfg_w, cfg_h   - frame start pulse and geometry (sampled at start)
//   in_valid/in_ready/in_data    - pixel input handshake
//   win_valid/win_ready/win_data - window output handshake
//   win_x, win_y          - top-left coordinate of the window on win_data
//   busy                  - frame in progress (RUN or DRAIN)
//   done                  - one-cycle pulse once the last window has left
//   err                   - sticky bad-configuration flag, cleared by start
// -----------------------------------------------------------------------------
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int MAX_W  = 1024,
    parameter int DATA_W = PIX_W
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [15:0]                    cfg_w,
    input  logic [15:0]                    cfg_h,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           in_ready,
    output logic                           win_valid,
    input  logic                           win_ready,
    output logic [WIN_PIXELS*DATA_W-1:0]   win_data,
    output logic [15:0]                    win_x,
    output logic [15:0]                    win_y,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int          AW        = $clog2(MAX_W);
    localparam logic [15:0] MAX_W_16  = 16'(MAX_W);

    state_t                          r_state;
    state_t                          w_state_next;
    logic [15:0]                     r_w;
    logic [15:0]                     r_h;
    logic [15:0]                     r_col;
    logic [15:0]                     r_row;
    logic                            r_err;
    logic                            r_win_valid;
    logic [WIN_PIXELS*DATA_W-1:0]    r_win_data;
    logic [15:0]                     r_win_x;
    logic [15:0]                     r_win_y;
    logic [DATA_W-1:0]               r_win   [3][3];

    logic                            w_accept;
    logic                            w_cfg_ok;
    logic                            w_last_col;
    logic                            w_last_pix;
    logic                            w_emit;
    logic [DATA_W-1:0]               w_a_rd;
    logic [DATA_W-1:0]               w_b_rd;
    logic [DATA_W-1:0]               w_new_col [3];
    logic [DATA_W-1:0]               w_shift   [3][3];
    logic [WIN_PIXELS*DATA_W-1:0]    w_shift_flat;

    assign w_cfg_ok   = (cfg_w >= 16'd3) && (cfg_w <= MAX_W_16) && (cfg_h >= 16'd3);
    assign in_ready   = (r_state == ST_RUN) && (!r_win_valid || win_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_last_col = (r_col == r_w - 16'd1);
    assign w_last_pix = w_last_col && (r_row == r_h - 16'd1);
    assign w_emit     = w_accept && (r_col >= 16'd2) && (r_row >= 16'd2);

    // Line buffer A holds the previous row; as it is overwritten its old
    // entry migrates into B, which therefore holds the row before that.
    sobel_line_buffer #(.DEPTH(MAX_W), .DATA_W(DATA_W)) u_lb_a (
        .clk   (clk),
        .we    (w_accept),
        .addr  (r_col[AW-1:0]),
        .wdata (in_data),
        .rdata (w_a_rd)
    );

    sobel_line_buffer #(.DEPTH(MAX_W), .DATA_W(DATA_W)) u_lb_b (
        .clk   (clk),
        .we    (w_accept),
        .addr  (r_col[AW-1:0]),
        .wdata (w_a_rd),
        .rdata (w_b_rd)
    );

    // Incoming column, oldest row on top.
    assign w_new_col[0] = w_b_rd;
    assign w_new_col[1] = w_a_rd;
    assign w_new_col[2] = in_data;

    // Window after shifting left by one column and appending the new column.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            for (gj = 0; gj < 3; gj++) begin : g_col
                if (gj == 2) begin : g_new
                    assign w_shift[gi][gj] = w_new_col[gi];
                end else begin : g_old
                    assign w_shift[gi][gj] = r_win[gi][gj+1];
                end
                assign w_shift_flat[win_idx(gi, gj)*DATA_W +: DATA_W] = w_shift[gi][gj];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start && w_cfg_ok)          w_state_next = ST_RUN;
            ST_RUN:   if (w_accept && w_last_pix)     w_state_next = ST_DRAIN;
            ST_DRAIN: if (!r_win_valid || win_ready)  w_state_next = ST_DONE;
            ST_DONE:                                  w_state_next = ST_IDLE;
            default:                                  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_w         <= '0;
            r_h         <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_err       <= 1'b0;
            r_win_valid <= 1'b0;
            r_win_data  <= '0;
            r_win_x     <= '0;
            r_win_y     <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                if (w_cfg_ok) begin
                    r_w   <= cfg_w;
                    r_h   <= cfg_h;
                    r_col <= '0;
                    r_row <= '0;
                    r_err <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end

            // The shift window runs across row boundaries; the first two
            // columns of each row flush the previous row's tail out.
            if (w_accept) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        r_win[r][c] <= w_shift[r][c];
                    end
                end
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + 16'd1;
                end else begin
                    r_col <= r_col + 16'd1;
                end
            end

            // A load only happens when the register is empty or draining
            // this cycle, so held data is never overwritten during a stall.
            if (w_emit) begin
                r_win_valid <= 1'b1;
                r_win_data  <= w_shift_flat;
                r_win_x     <= r_col - 16'd2;
                r_win_y     <= r_row - 16'd2;
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign win_valid = r_win_valid;
    assign win_data  = r_win_data;
    assign win_x     = r_win_x;
    assign win_y     = r_win_y;
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign err       = r_err;

endmodule

// File: tb/tb_sobel_window_gen.sv
module tb_sobel_window_gen;

    localparam int MAX_W = 1024;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_w = '0;
    logic [15:0] cfg_h = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        win_valid;
    logic        win_ready = 1'b0;
    logic [71:0] win_data;
    logic [15:0] win_x;
    logic [15:0] win_y;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Results of the last run_frame call
    logic [7:0]  img [];
    int          n_win;
    int          sb_bad;
    int          stall_viol;
    int          timed_out;
    int          done_cyc;
    int          last_hs_cyc;
    logic        busy_after_done;
    logic [71:0] first_data;
    int          q_x [$];
    int          q_y [$];

    always #5 clk = ~clk;

    sobel_window_gen #(.MAX_W(MAX_W), .DATA_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .cfg_w     (cfg_w),
        .cfg_h     (cfg_h),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_x     (win_x),
        .win_y     (win_y),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Runs one frame from a start pulse until done (called at posedge+1).
    // mode 0: ramp 4r+c, mode 1: random pixels. pv/pr: in_valid/win_ready %.
    // Every handshaked window is scored against windows cut from img[].
    task automatic run_frame(input int w, input int h, input int mode,
                             input int pv, input int pr);
        int          pix;
        int          cyc;
        int          got_done;
        int          total;
        int          ex;
        int          ey;
        logic [71:0] ed;
        logic        prev_stall;
        logic [71:0] prev_data;
        logic [15:0] prev_x;
        logic [15:0] prev_y;
        img = new[w * h];
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                img[y*w + x] = (mode == 0) ? 8'((4*y + x) & 255) : 8'($urandom_range(0, 255));
        total = (w - 2) * (h - 2);
        n_win = 0; sb_bad = 0; stall_viol = 0; timed_out = 0;
        done_cyc = -1; last_hs_cyc = -1; first_data = '0;
        q_x.delete(); q_y.delete();
        prev_stall = 1'b0; prev_data = '0; prev_x = '0; prev_y = '0;
        $display("frame start %0dx%0d mode=%0d", w, h, mode);
        start = 1'b1; cfg_w = 16'(w); cfg_h = 16'(h);
        @(posedge clk); #1;
        start = 1'b0;
        pix = 0; cyc = 0; got_done = 0;
        while (!got_done && cyc < 40 * w * h + 200) begin
            in_valid  = (pix < w*h) && ($urandom_range(0, 99) < pv);
            in_data   = (pix < w*h) ? img[pix] : 8'h00;
            win_ready = ($urandom_range(0, 99) < pr);
            @(negedge clk);
            if (prev_stall && (!win_valid || win_data !== prev_data ||
                               win_x !== prev_x || win_y !== prev_y))
                stall_viol++;
            if (win_valid && !win_ready && in_ready) stall_viol++;
            prev_stall = win_valid && !win_ready;
            prev_data = win_data; prev_x = win_x; prev_y = win_y;
            if (win_valid && win_ready) begin
                if (n_win >= total) begin
                    sb_bad++;
                    $display("win %0d extra x=%0d y=%0d", n_win, win_x, win_y);
                end else begin
                    ex = n_win % (w - 2);
                    ey = n_win / (w - 2);
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            ed[(3*r+c)*8 +: 8] = img[(ey+r)*w + ex + c];
                    if (win_data !== ed || win_x !== 16'(ex) || win_y !== 16'(ey)) begin
                        sb_bad++;
                        $display("win %0d bad: got x=%0d y=%0d d=%h want x=%0d y=%0d d=%h",
                                 n_win, win_x, win_y, win_data, ex, ey, ed);
                    end else begin
                        $display("win %0d x=%0d y=%0d d=%h ok", n_win, win_x, win_y, win_data);
                    end
                end
                if (n_win == 0) first_data = win_data;
                q_x.push_back(int'(win_x));
                q_y.push_back(int'(win_y));
                n_win++;
                last_hs_cyc = cyc;
            end
            if (in_valid && in_ready) pix++;
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
            cyc++;
            @(posedge clk); #1;
        end
        if (!got_done) timed_out = 1;
        in_valid = 1'b0;
        win_ready = 1'b1;
        busy_after_done = busy;
        $display("frame end %0dx%0d windows=%0d cycles=%0d", w, h, n_win, cyc);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, win_valid, busy, done, err} !== 5'b0 || win_data !== '0 ||
            win_x !== '0 || win_y !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b busy=%b done=%b err=%b d=%h x=%0d y=%0d want all 0",
                     in_ready, win_valid, busy, done, err, win_data, win_x, win_y);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got rdy=%b busy=%b want 0 0", in_ready, busy);
        end
    endtask

    task automatic test_ramp_4x4();
        int          vals [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int          ex_x [4] = '{0, 1, 0, 1};
        int          ex_y [4] = '{0, 0, 1, 1};
        logic [71:0] e;
        int          extra_done;
        for (int i = 0; i < 9; i++) e[i*8 +: 8] = 8'(vals[i]);
        run_frame(4, 4, 0, 100, 100);
        checks++;
        if (timed_out != 0 || n_win != 4 || sb_bad != 0) begin
            errors++;
            $display("FAIL ramp_windows: got n=%0d bad=%0d timeout=%0d want 4 0 0", n_win, sb_bad, timed_out);
        end
        checks++;
        if (first_data !== e) begin
            errors++;
            $display("FAIL ramp_first_window: got %h want %h", first_data, e);
        end
        for (int i = 0; i < 4 && i < q_x.size(); i++) begin
            checks++;
            if (q_x[i] != ex_x[i] || q_y[i] != ex_y[i]) begin
                errors++;
                $display("FAIL ramp_order[%0d]: got (%0d,%0d) want (%0d,%0d)", i, q_x[i], q_y[i], ex_x[i], ex_y[i]);
            end
        end
        checks++;
        if (done_cyc != last_hs_cyc + 1) begin
            errors++;
            $display("FAIL ramp_done_timing: got done cycle %0d want %0d", done_cyc, last_hs_cyc + 1);
        end
        extra_done = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) extra_done++;
            @(posedge clk); #1;
        end
        checks++;
        if (extra_done != 0) begin
            errors++;
            $display("FAIL ramp_done_once: got %0d extra pulses want 0", extra_done);
        end
    endtask

    task automatic test_min_3x3();
        logic [71:0] e;
        run_frame(3, 3, 1, 100, 100);
        for (int i = 0; i < 9; i++) e[i*8 +: 8] = img[i];
        checks++;
        if (timed_out != 0 || n_win != 1 || sb_bad != 0 || first_data !== e) begin
            errors++;
            $display("FAIL min_frame: got n=%0d bad=%0d d=%h want 1 0 %h", n_win, sb_bad, first_data, e);
        end
        checks++;
        if (busy_after_done !== 1'b0) begin
            errors++;
            $display("FAIL min_busy_after_done: got %b want 0", busy_after_done);
        end
    endtask

    task automatic test_bad_config();
        int w_list [2] = '{2, MAX_W + 1};
        int h_list [2] = '{100, 10};
        int rdy_seen;
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; cfg_w = 16'(w_list[k]); cfg_h = 16'(h_list[k]);
            @(posedge clk); #1;
            start = 1'b0;
            in_valid = 1'b1;
            rdy_seen = 0;
            for (int i = 0; i < 4; i++) begin
                if (in_ready || busy) rdy_seen++;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            $display("bad start w=%0d h=%0d err=%b", w_list[k], h_list[k], err);
            checks++;
            if (err !== 1'b1 || rdy_seen != 0) begin
                errors++;
                $display("FAIL bad_config_%0d: got err=%b active_cycles=%0d want 1 0", k, err, rdy_seen);
            end
        end
        run_frame(4, 3, 1, 80, 80);
        checks++;
        if (err !== 1'b0 || n_win != 2 || sb_bad != 0 || timed_out != 0) begin
            errors++;
            $display("FAIL bad_config_recover: got err=%b n=%0d bad=%0d want 0 2 0", err, n_win, sb_bad);
        end
    endtask

    task automatic test_random_stalls();
        run_frame(32, 16, 1, 70, 50);
        checks++;
        if (timed_out != 0 || n_win != 30 * 14 || sb_bad != 0) begin
            errors++;
            $display("FAIL random_windows: got n=%0d bad=%0d timeout=%0d want %0d 0 0", n_win, sb_bad, timed_out, 30*14);
        end
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("FAIL random_stall_rules: got %0d violations want 0", stall_viol);
        end
    endtask

    task automatic test_reset_midframe();
        start = 1'b1; cfg_w = 16'd6; cfg_h = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; win_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({in_ready, win_valid, busy, done} !== 4'b0 || win_data !== '0 ||
            win_x !== '0 || win_y !== '0) begin
            errors++;
            $display("FAIL midframe_reset: got rdy=%b v=%b busy=%b done=%b d=%h want all 0",
                     in_ready, win_valid, busy, done, win_data);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        run_frame(5, 4, 1, 90, 90);
        checks++;
        if (timed_out != 0 || n_win != 6 || sb_bad != 0 || stall_viol != 0) begin
            errors++;
            $display("FAIL after_reset_frame: got n=%0d bad=%0d stall=%0d want 6 0 0", n_win, sb_bad, stall_viol);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(8, 8, 1, 100, 100);
        checks++;
        if (timed_out != 0 || n_win != 36 || sb_bad != 0) begin
            errors++;
            $display("FAIL b2b_first: got n=%0d bad=%0d want 36 0", n_win, sb_bad);
        end
        run_frame(4, 4, 1, 100, 100);
        checks++;
        if (timed_out != 0 || n_win != 4 || sb_bad != 0) begin
            errors++;
            $display("FAIL b2b_second: got n=%0d bad=%0d want 4 0", n_win, sb_bad);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_4x4();
        test_min_3x3();
        test_bad_config();
        test_random_stalls();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
